// File: rtl/fcvt_wu_s_wb_pkg.sv
// Shared FP constants and operand classification for the FCVT.WU.S writeback path.
package fpu_pkg;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int FRAC_W   = 23;
    localparam int UINT_W   = 32;

    // Largest exponent whose value the converter still delivers exactly
    localparam int EXP_EXACT = EXP_BIAS + FRAC_W;
    // First exponent whose magnitude no longer fits 32 bits
    localparam int EXP_OVF   = EXP_BIAS + UINT_W;

    localparam logic [31:0] UINT32_MAX = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORM,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

endpackage

// File: rtl/fcvt_wu_s_wb_if.sv
// Handshake bundle between upstream converter, this stage and integer writeback.
interface fcvt_wu_s_wb_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_rs1;
    logic [31:0]      in_conv;
    logic [TAG_W-1:0] in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_rd;
    logic [4:0]       out_fflags;
    logic             flags_clr;
    logic [4:0]       fflags_acc;

    modport master (
        output in_valid, in_rs1, in_conv, in_rd, out_ready, flags_clr,
        input  in_ready, out_valid, out_data, out_rd, out_fflags, fflags_acc
    );

    modport slave (
        input  in_valid, in_rs1, in_conv, in_rd, out_ready, flags_clr,
        output in_ready, out_valid, out_data, out_rd, out_fflags, fflags_acc
    );
endinterface

// File: rtl/fcvt_wu_s_classify.sv
// Combinational RISC-V FCVT.WU.S result/flag selection around the raw converter output.
module fcvt_wu_s_classify
    import fpu_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] conv,
    output logic [31:0] data,
    output logic [4:0]  fflags
);

    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    fp_class_t   cls;

    assign sign = rs1[31];
    assign exp  = rs1[30:23];
    assign man  = rs1[22:0];

    // Fraction bits below the binary point are dropped by RTZ truncation
    function automatic logic lost_bits(input logic [7:0] e, input logic [22:0] m);
        logic [7:0]  sh;
        logic [23:0] mask;
        sh   = 8'(EXP_EXACT) - e;
        mask = (24'h1 << sh) - 24'h1;
        return |(m & mask[22:0]);
    endfunction

    // Exponents the converter cannot shift: the significand moves left past bit 23
    function automatic logic [31:0] shift_big(input logic [7:0] e, input logic [22:0] m);
        logic [7:0] sh;
        sh = e - 8'(EXP_EXACT);
        return {8'h00, 1'b1, m} << sh;
    endfunction

    always_comb begin
        cls = NORMAL;
        if (exp == 8'd0)
            cls = (man == '0) ? ZERO : SUBNORM;
        else if (exp == 8'(EXP_MAX))
            cls = (man == '0) ? INF : NAN;
    end

    always_comb begin
        data   = '0;
        fflags = '0;
        unique case (cls)
            NAN: begin
                data           = UINT32_MAX;
                fflags[FLAG_NV] = 1'b1;
            end
            INF: begin
                data           = sign ? 32'h0 : UINT32_MAX;
                fflags[FLAG_NV] = 1'b1;
            end
            ZERO: ;
            SUBNORM: fflags[FLAG_NX] = 1'b1;
            NORMAL: begin
                if (exp < 8'(EXP_BIAS)) begin
                    fflags[FLAG_NX] = 1'b1;
                end else if (sign) begin
                    fflags[FLAG_NV] = 1'b1;
                end else if (exp >= 8'(EXP_OVF)) begin
                    data           = UINT32_MAX;
                    fflags[FLAG_NV] = 1'b1;
                end else if (exp > 8'(EXP_EXACT)) begin
                    data = shift_big(exp, man);
                end else begin
                    data           = conv;
                    fflags[FLAG_NX] = lost_bits(exp, man);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fcvt_wu_s_wb.sv
// FCVT.WU.S writeback stage: classify at push, small FIFO to writeback, sticky accrued flags.
module fcvt_wu_s_wb
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    fcvt_wu_s_wb_if.slave    bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] rd_mem   [DEPTH];
    logic [4:0]       flag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       acc;

    logic        valid;
    logic        push;
    logic        pop;
    logic [31:0] cls_data;
    logic [4:0]  cls_flags;

    fcvt_wu_s_classify u_classify (
        .rs1    (bus.in_rs1),
        .conv   (bus.in_conv),
        .data   (cls_data),
        .fflags (cls_flags)
    );

    assign valid        = (count != '0);
    assign bus.in_ready = (count < CNT_W'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = valid && bus.out_ready;

    // Outputs read the head directly; an empty FIFO presents zeros
    assign bus.out_valid  = valid;
    assign bus.out_data   = valid ? data_mem[rd_ptr] : '0;
    assign bus.out_rd     = valid ? rd_mem[rd_ptr]   : '0;
    assign bus.out_fflags = valid ? flag_mem[rd_ptr] : '0;
    assign bus.fflags_acc = acc;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= cls_data;
            rd_mem[wr_ptr]   <= bus.in_rd;
            flag_mem[wr_ptr] <= cls_flags;
        end
    end

    // A clear coinciding with a retire keeps only the retiring op's flags
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn)
            acc <= '0;
        else if (bus.flags_clr)
            acc <= pop ? flag_mem[rd_ptr] : 5'h00;
        else if (pop)
            acc <= acc | flag_mem[rd_ptr];
    end

endmodule

// File: tb/tb_fcvt_wu_s_wb.sv
// Bench for fcvt_wu_s_wb: directed and random ops scored against a magnitude-based reference.
module tb_fcvt_wu_s_wb;

    localparam int TAG_W = 5;
    localparam int DEPTH = 2;
    localparam logic [4:0] F_NV = 5'h10;
    localparam logic [4:0] F_NX = 5'h01;

    typedef struct packed {
        logic [31:0]      d;
        logic [TAG_W-1:0] rd;
        logic [4:0]       f;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    ent_t q[$];
    logic [4:0] acc_m;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fcvt_wu_s_wb_if #(.TAG_W(TAG_W)) bus ();

    fcvt_wu_s_wb #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    // Reference: value = 1.m * 2^(e-127), truncated toward zero, then range-checked
    function automatic ent_t ref_op(input logic [31:0] rs1, input logic [TAG_W-1:0] rd);
        ent_t r;
        int ue;
        longint unsigned mant;
        longint unsigned ip;
        r.rd = rd;
        r.d  = 32'h0;
        r.f  = 5'h00;
        mant = {40'd0, 1'b1, rs1[22:0]};
        ue   = int'(rs1[30:23]) - 127;
        if (rs1[30:23] == 8'hFF) begin
            r.f = F_NV;
            r.d = (rs1[22:0] != 0 || !rs1[31]) ? 32'hFFFFFFFF : 32'h0;
        end else if (rs1[30:0] != 31'h0) begin
            if (ue < 0) begin
                r.f = F_NX;
            end else if (rs1[31]) begin
                r.f = F_NV;
            end else if (ue >= 32) begin
                r.d = 32'hFFFFFFFF;
                r.f = F_NV;
            end else begin
                ip  = (ue >= 23) ? (mant << (ue - 23)) : (mant >> (23 - ue));
                r.d = ip[31:0];
                if (ue < 23 && (ip << (23 - ue)) != mant)
                    r.f = F_NX;
            end
        end
        return r;
    endfunction

    // What the upstream RTZ converter would hand over; garbage where it is not used
    function automatic logic [31:0] mk_conv(input logic [31:0] rs1);
        int e;
        logic [23:0] sig;
        e   = int'(rs1[30:23]);
        sig = {1'b1, rs1[22:0]};
        if (!rs1[31] && e >= 127 && e <= 150)
            return {8'h00, sig >> (150 - e)};
        return $urandom;
    endfunction

    function automatic logic [31:0] rand_rs1();
        logic [7:0]  e;
        logic [22:0] m;
        int k;
        k = $urandom_range(0, 5);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(120, 160));
            default: e = 8'($urandom);
        endcase
        m = ($urandom_range(0, 4) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] rs1, input logic [TAG_W-1:0] rd);
        bus.in_valid = v;
        bus.in_rs1   = rs1;
        bus.in_conv  = mk_conv(rs1);
        bus.in_rd    = rd;
    endtask

    task automatic check_all();
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_rd", 32'(bus.out_rd), 32'(q[0].rd));
            chk("out_fflags", 32'(bus.out_fflags), 32'(q[0].f));
        end
        chk("fflags_acc", 32'(bus.fflags_acc), 32'(acc_m));
    endtask

    task automatic step();
        ent_t nxt;
        ent_t head;
        bit push;
        bit pop;
        bit clr;
        push = bus.in_valid && (q.size() < DEPTH);
        pop  = bus.out_ready && (q.size() != 0);
        clr  = bus.flags_clr;
        nxt  = ref_op(bus.in_rs1, bus.in_rd);
        head = (q.size() != 0) ? q[0] : '0;
        @(posedge clk);
        #1;
        if (clr)
            acc_m = pop ? head.f : 5'h00;
        else if (pop)
            acc_m = acc_m | head.f;
        if (pop)
            void'(q.pop_front());
        if (push)
            q.push_back(nxt);
        check_all();
    endtask

    task automatic one(input logic [31:0] rs1, input logic [TAG_W-1:0] rd,
                       input logic [31:0] exp_d, input logic [4:0] exp_f);
        drive(1'b1, rs1, rd);
        bus.out_ready = 1'b1;
        step();
        chk("direct_data", bus.out_data, exp_d);
        chk("direct_flags", 32'(bus.out_fflags), 32'(exp_f));
        drive(1'b0, 32'h0, '0);
        step();
    endtask

    initial begin
        resetn        = 1'b1;
        bus.out_ready = 1'b0;
        bus.flags_clr = 1'b0;
        drive(1'b0, 32'h0, '0);
        acc_m = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'h0);
        chk("rst_out_fflags", 32'(bus.out_fflags), 32'h0);
        chk("rst_acc", 32'(bus.fflags_acc), 32'h0);
        resetn = 1'b0;
        step();

        one(32'h3FC00000, 5'd1, 32'h00000001, 5'h01);
        one(32'h4F800000, 5'd2, 32'hFFFFFFFF, 5'h10);
        chk("acc_after_two", 32'(bus.fflags_acc), 32'h11);
        one(32'h7FC00000, 5'd3, 32'hFFFFFFFF, 5'h10);
        one(32'hFF800000, 5'd4, 32'h00000000, 5'h10);
        one(32'h7F800000, 5'd5, 32'hFFFFFFFF, 5'h10);
        one(32'hBF800000, 5'd6, 32'h00000000, 5'h10);
        one(32'hBF000000, 5'd7, 32'h00000000, 5'h01);
        one(32'h80000000, 5'd8, 32'h00000000, 5'h00);
        one(32'h00000001, 5'd9, 32'h00000000, 5'h01);
        one(32'h4B800001, 5'd10, 32'h01000002, 5'h00);
        one(32'h4F7FFFFF, 5'd11, 32'hFFFFFF00, 5'h00);
        one(32'h4F000000, 5'd12, 32'h80000000, 5'h00);
        one(32'h4B7FFFFF, 5'd13, 32'h00FFFFFF, 5'h00);
        one(32'h3F800000, 5'd14, 32'h00000001, 5'h00);

        // clear coinciding with a retire, then a plain clear
        drive(1'b1, 32'h3FC00000, 5'd15);
        step();
        drive(1'b0, 32'h0, '0);
        bus.flags_clr = 1'b1;
        step();
        chk("clr_with_pop", 32'(bus.fflags_acc), 32'h01);
        step();
        chk("clr_only", 32'(bus.fflags_acc), 32'h00);
        bus.flags_clr = 1'b0;

        // backpressure with three offered ops
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h40000000, 5'd21);
        step();
        drive(1'b1, 32'h40400000, 5'd22);
        step();
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        drive(1'b1, 32'h40800000, 5'd23);
        step();
        chk("held_in_ready", 32'(bus.in_ready), 32'h0);
        chk("held_head_rd", 32'(bus.out_rd), 32'd21);
        bus.out_ready = 1'b1;
        step();
        chk("pop1_head_rd", 32'(bus.out_rd), 32'd22);
        chk("pop1_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        chk("pop2_head_rd", 32'(bus.out_rd), 32'd23);
        chk("pop2_data", bus.out_data, 32'd4);
        drive(1'b0, 32'h0, '0);
        step();
        chk("drained", 32'(bus.out_valid), 32'h0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_rs1(), TAG_W'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flags_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        bus.flags_clr = 1'b0;

        // asynchronous reset with entries queued
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h4F800000, 5'd30);
        step();
        drive(1'b1, 32'h3FC00000, 5'd31);
        step();
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, '0);
        step();
        bus.out_ready = 1'b0;
        chk("pre_rst_acc", 32'(bus.fflags_acc), 32'(acc_m));
        #2;
        resetn = 1'b1;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'h0);
        chk("async_acc", 32'(bus.fflags_acc), 32'h0);
        q.delete();
        acc_m = 5'h00;
        @(posedge clk);
        #1;
        resetn = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
        one(32'h41200000, 5'd9, 32'd10, 5'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fcvt_wu_s_wb.md
Name: fcvt_wu_s_wb

Overview:
- Writeback stage directly downstream of the combinational FCVT.WU.S converter.
- Takes the FP source operand, the converter's raw truncated result and the destination tag. Applies RISC-V saturation and exception rules, including the exp 151..158 range the converter cannot shift.
- Buffers results in a small FIFO with valid/ready toward integer register writeback, and keeps a sticky accrued-fflags register for fcsr.

Parameters:
- TAG_W, 5, width of destination register tag.
- DEPTH, 2, FIFO entries; legal values are 2 or 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset; asynchronous, active-high (asserted when 1).
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  stage can accept; equals count<DEPTH, driven from registered state.
- in_rs1  in  32  IEEE-754 single source operand.
- in_conv  in  32  converter result (RTZ magnitude for exp<=150).
- in_rd  in  TAG_W  destination tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts.
- out_data  out  32  final unsigned integer.
- out_rd  out  TAG_W  tag of head entry.
- out_fflags  out  5  per-op flags of head entry {NV,DZ,OF,UF,NX}.
- flags_clr  in  1  synchronous clear of accrued flags.
- fflags_acc  out  5  sticky OR of all retired out_fflags.

Behaviour:
- Reset, asynchronous: count=0, pointers=0, out_valid=0, out_data=0, out_rd=0, out_fflags=0, fflags_acc=0. Asserting reset mid-operation discards all entries; in_ready=1 on the first cycle after release.
- Push = in_valid&&in_ready. Pop = out_valid&&out_ready.
- Latency: an op pushed at edge N is visible on the outputs after edge N if the FIFO was empty. Throughput is 1 op/cycle.
- Order is strictly FIFO. With push and pop in the same cycle, count is unchanged, including at count 1.
- At count=DEPTH, in_ready=0 and no push occurs even if pop happens that cycle. in_ready rises the cycle after the pop.
- out_data, out_rd and out_fflags are held stable while out_valid&&!out_ready.
- Result and flags are computed at push time from in_rs1 (s=bit31, e=bits30:23, m=bits22:0) and in_conv:
  - e=255, m!=0 (NaN, any sign): 0xFFFFFFFF, NV.
  - e=255, m=0, s=0: 0xFFFFFFFF, NV.
  - e=255, m=0, s=1: 0, NV.
  - e=0, m=0 (±0): 0, no flags.
  - e=0, m!=0, or 1<=e<=126, any sign: 0, NX. Negative values in (-1,0) are not NV.
  - s=1, 127<=e<=254: 0, NV.
  - s=0, e>=159: 0xFFFFFFFF, NV.
  - s=0, 151<=e<=158: {1,m} << (e-150), computed locally; no flags.
  - s=0, 127<=e<=150: in_conv. NX if any of the low (150-e) bits of m are nonzero; no bits are dropped at e=150.
- DZ, OF and UF are always 0.
- fflags_acc, evaluated every edge:
  - flags_clr only: acc=0.
  - pop only: acc |= out_fflags.
  - flags_clr and pop together: acc = out_fflags of the popped entry.

Decomposition:
- Package fpu_pkg holds:
  - FLAG_NV=4, FLAG_DZ=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0.
  - EXP_BIAS=127, EXP_MAX=255, UINT32_MAX=32'hFFFFFFFF.
  - Enum fp_class_t: ZERO, SUBNORM, NORMAL, INF, NAN.
- Sub-module fcvt_wu_s_classify: purely combinational; takes (in_rs1, in_conv) and produces (data, fflags).
- The top level holds the FIFO storage, pointers, count and the accrued-flags register.

Test Plan:
- Basic op: rs1=0x3FC00000 (1.5), conv=1, out_ready=1 -> next cycle out_valid=1, data=0x00000001, fflags=0x01, rd echoed.
- Saturation: rs1=0x4F800000 (2^32) -> data 0xFFFFFFFF, fflags 0x10. rs1=0x7FC00000 -> 0xFFFFFFFF, 0x10. rs1=0xFF800000 -> 0, 0x10.
- Negatives: rs1=0xBF800000 (-1.0) -> 0, 0x10. rs1=0xBF000000 (-0.5) -> 0, 0x01. rs1=0x80000000 -> 0, 0x00.
- Local shift range: rs1=0x4B800001 (exp 151) -> data 0x01000002, fflags 0. rs1=0x4F7FFFFF -> 0xFFFFFF00, 0.
- Backpressure: out_ready=0, offer 3 ops -> in_ready=0 after 2 pushes and third held. Raise out_ready -> ops retire in order 1,2,3 with one per cycle, and third accepted the cycle after first pop.
- Flags and reset: retire 1.5 then 2^32 -> fflags_acc=0x11. flags_clr with a pop of 0x01 in the same cycle -> acc=0x01. Assert resetn=1 with 2 entries queued -> out_valid=0, acc=0 immediately, in_ready=1 after release.
